// File: rtl/scan_serializer_pkg.sv
// Shared types and sizing helpers for the scan serializer.
package scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } scan_state_e;

    function automatic int beats_f(input int data_w, input int lanes);
        return (data_w + lanes - 1) / lanes;
    endfunction

    // Lane l of beat b carries captured bit b*lanes+l.
    function automatic int lane_bit_idx(input int beat, input int lane, input int lanes);
        return beat * lanes + lane;
    endfunction

endpackage

// File: rtl/scan_serializer_beat_mux.sv
// Selects the LANES bits of the snapshot belonging to one beat; bits past DATA_W read as 0.
module scan_beat_mux
    import scan_pkg::*;
#(
    parameter int DATA_W = 19,
    parameter int LANES  = 1,
    parameter int BEAT_W = 5
) (
    input  logic [DATA_W-1:0] shadow,
    input  logic [BEAT_W-1:0] beat,
    output logic [LANES-1:0]  lanes_out
);

    localparam int BEATS = beats_f(DATA_W, LANES);
    localparam int PAD_W = BEATS * LANES;

    logic [PAD_W-1:0] padded;

    assign padded = PAD_W'(shadow);

    // Beat values at or beyond BEATS (the parity slot) select nothing.
    always_comb begin
        lanes_out = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (beat == BEAT_W'(b)) begin
                for (int l = 0; l < LANES; l++) begin
                    lanes_out[l] = padded[lane_bit_idx(b, l, LANES)];
                end
            end
        end
    end

endmodule

// File: rtl/scan_serializer.sv
// Snapshot-and-stream debug scan-out over LANES pins; SCAN_SERIALIZER_PARITY_EN adds a parity beat.
module scan_serializer
    import scan_pkg::*;
#(
    parameter int DATA_W     = 19,
    parameter int LANES      = 1,
    parameter int CONTINUOUS = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] scan_data,
    output logic [LANES-1:0]  scan_out,
    output logic              scan_valid,
    output logic              scan_last,
    output logic              busy
);

    localparam int BEATS  = beats_f(DATA_W, LANES);
    localparam int BEAT_W = $clog2(BEATS + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [BEAT_W-1:0] PAR_BEAT  = BEAT_W'(BEATS);
`ifdef SCAN_SERIALIZER_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif
    localparam bit CONT_EN = (CONTINUOUS != 0);

    scan_state_e       state_q, state_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [LANES-1:0]  par_q, par_d;
    logic [LANES-1:0]  out_q, out_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              load;
    logic [LANES-1:0]  mux_out;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        beat_d   = beat_q;
        load     = 1'b0;
        case (state_q)
            S_IDLE: load = start && !abort;
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                    beat_d  = '0;
                end else if (beat_q != LAST_BEAT) begin
                    beat_d = beat_q + 1'b1;
                end else if (PARITY_EN) begin
                    state_d = S_PARITY;
                    beat_d  = PAR_BEAT;
                end else if (CONT_EN) begin
                    load = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    beat_d  = '0;
                end
            end
            S_PARITY: begin
                if (!abort && CONT_EN) begin
                    load = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    beat_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                beat_d  = '0;
            end
        endcase
        // Start and continuous restart share one capture path.
        if (load) begin
            state_d  = S_SHIFT;
            shadow_d = scan_data;
            beat_d   = '0;
        end
    end

    scan_beat_mux #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .BEAT_W (BEAT_W)
    ) u_beat_mux (
        .shadow    (shadow_d),
        .beat      (beat_d),
        .lanes_out (mux_out)
    );

    // Outputs are computed from the next state so every pin leaves a flop.
    always_comb begin
        out_d   = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        par_d   = par_q;
        case (state_d)
            S_SHIFT: begin
                valid_d = 1'b1;
                out_d   = mux_out;
                last_d  = !PARITY_EN && (beat_d == LAST_BEAT);
                par_d   = (beat_d == '0) ? mux_out : (par_q ^ mux_out);
            end
            S_PARITY: begin
                valid_d = 1'b1;
                out_d   = par_q;
                last_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            shadow_q <= '0;
            beat_q   <= '0;
            par_q    <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            beat_q   <= beat_d;
            par_q    <= par_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
        end
    end

    assign scan_out   = out_q;
    assign scan_valid = valid_q;
    assign scan_last  = last_q;
    assign busy       = valid_q;

endmodule
